// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters plus sync, blanking and frame-start flags.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] HB_START   = 11'(H_ACTIVE);
    localparam logic [10:0] VB_START   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] h_nxt, v_nxt;
    logic        wrap_nxt;

    always_comb begin
        h_nxt = (hcount_out == H_LAST) ? 11'd0 : hcount_out + 11'd1;
        v_nxt = vcount_out;
        if (hcount_out == H_LAST)
            v_nxt = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        wrap_nxt = (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end

    // Flags decode the next-state counts so they land in the same cycle as the position they describe.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount_out  <= h_nxt;
            vcount_out  <= v_nxt;
            hblnk_out   <= (h_nxt >= HB_START);
            vblnk_out   <= (v_nxt >= VB_START);
            hsync_out   <= (h_nxt >= HS_START) && (h_nxt <= HS_END);
            vsync_out   <= (v_nxt >= VS_START) && (v_nxt <= VS_END);
            frame_start <= wrap_nxt;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (en && wrap_nxt)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line/enable/reset behaviour and a
// tiny-timing instance (16 x 11) for frame-level behaviour within a short run.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // default-timing instance
    logic        d_rst_n, d_en;
    logic [10:0] d_hc, d_vc;
    logic        d_hs, d_vs, d_hb, d_vb, d_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_fcnt;
`endif

    vga_timing_gen u_dflt (
        .pclk(pclk), .rst_n(d_rst_n), .en(d_en),
        .hcount_out(d_hc), .vcount_out(d_vc),
        .hsync_out(d_hs), .vsync_out(d_vs),
        .hblnk_out(d_hb), .vblnk_out(d_vb),
        .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_fcnt)
`endif
    );

    // small-timing instance: H 8+2+3+3 = 16, V 6+1+2+2 = 11, frame = 176 cycles
    logic        s_rst_n, s_en;
    logic [10:0] s_hc, s_vc;
    logic        s_hs, s_vs, s_hb, s_vb, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] s_fcnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .pclk(pclk), .rst_n(s_rst_n), .en(s_en),
        .hcount_out(s_hc), .vcount_out(s_vc),
        .hsync_out(s_hs), .vsync_out(s_vs),
        .hblnk_out(s_hb), .vblnk_out(s_vb),
        .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_fcnt)
`endif
    );

    initial begin
        int seq_err, hs_cnt, hs_first, hs_last, hb_first, fs_seen, hold_err;
        int mh, mv, e_h, e_v, e_hb, e_vb, e_hs, e_vs, e_fs, fs_cnt, last_fs, per_err, vs_cyc, fc_err;

        d_rst_n = 1'b0; d_en = 1'b0;
        s_rst_n = 1'b0; s_en = 1'b0;
        #3;
        check("reset_hcount", d_hc, 0);
        check("reset_vcount", d_vc, 0);
        check("reset_flags", {d_hs, d_vs, d_hb, d_vb, d_fs}, 0);
`ifdef VGA_FRAME_CNT_EN
        check("reset_frame_cnt", d_fcnt, 0);
`endif

        // ---- first line at default timing ----
        tick(1);
        d_rst_n = 1'b1; d_en = 1'b1;
        tick(1);
        check("first_edge_hcount", d_hc, 1);
        check("first_edge_vcount", d_vc, 0);
        seq_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; hb_first = -1; fs_seen = 0;
        for (int i = 2; i <= 1343; i++) begin
            tick(1);
            if (d_hc != 11'(i) || d_vc != 11'd0) seq_err++;
            if (d_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_hb && hb_first < 0) hb_first = i;
            if (d_fs) fs_seen++;
        end
        check("line_sequence_errors", seq_err, 0);
        check("hsync_width", hs_cnt, 136);
        check("hsync_first_col", hs_first, 1048);
        check("hsync_last_col", hs_last, 1183);
        check("hblnk_rise_col", hb_first, 1024);
        check("no_frame_start_in_line", fs_seen, 0);
        tick(1);
        check("line_wrap_hcount", d_hc, 0);
        check("line_wrap_vcount", d_vc, 1);
        check("line_wrap_flags", {d_hs, d_hb, d_vb, d_fs}, 0);

        // ---- enable hold at (500,10) ----
        tick(10 * 1344 + 500 - 1344);
        check("pre_hold_pos", {21'(0), d_vc, d_hc} , {21'(0), 11'd10, 11'd500});
        d_en = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 37; i++) begin
            tick(1);
            if (d_hc != 11'd500 || d_vc != 11'd10 || d_fs) hold_err++;
        end
        check("hold_errors", hold_err, 0);
        d_en = 1'b1;
        tick(1);
        check("resume_hcount", d_hc, 501);
        check("resume_vcount", d_vc, 10);

        // ---- asynchronous reset mid-line ----
        tick(199);
        check("pre_reset_hcount", d_hc, 700);
        #2 d_rst_n = 1'b0;
        #1;
        check("async_reset_hcount", d_hc, 0);
        check("async_reset_vcount", d_vc, 0);
        check("async_reset_flags", {d_hs, d_vs, d_hb, d_vb, d_fs}, 0);
        tick(2);
        d_rst_n = 1'b1;
        tick(1);
        check("post_reset_hcount", d_hc, 1);
        check("post_reset_vcount", d_vc, 0);
        d_en = 1'b0;

        // ---- small-timing frames ----
        tick(1);
        s_rst_n = 1'b1; s_en = 1'b1;
        tick(175);
        check("corner_pos", {21'(0), s_vc, s_hc}, {21'(0), 11'd10, 11'd15});
        check("corner_blank", {s_hb, s_vb, s_fs}, 3'b110);
        tick(1);
        check("wrap_pos", {21'(0), s_vc, s_hc}, 0);
        check("wrap_frame_start", s_fs, 1);
        check("wrap_flags_clear", {s_hb, s_vb, s_hs, s_vs}, 0);
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_first", s_fcnt, 1);
`endif

        mh = 0; mv = 0;
        e_h = 0; e_v = 0; e_hb = 0; e_vb = 0; e_hs = 0; e_vs = 0; e_fs = 0;
        fs_cnt = 1; last_fs = 0; per_err = 0; vs_cyc = 0; fc_err = 0;
        for (int t = 1; t <= 352; t++) begin
            tick(1);
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 10) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (s_hc != 11'(mh)) e_h++;
            if (s_vc != 11'(mv)) e_v++;
            if (s_hb != (mh >= 8)) e_hb++;
            if (s_vb != (mv >= 6)) e_vb++;
            if (s_hs != (mh >= 10 && mh <= 12)) e_hs++;
            if (s_vs != (mv >= 7 && mv <= 8)) e_vs++;
            if (s_fs != (mh == 0 && mv == 0)) e_fs++;
            if (s_vs) vs_cyc++;
            if (s_fs) begin
                fs_cnt++;
                if (t - last_fs != 176) per_err++;
                last_fs = t;
`ifdef VGA_FRAME_CNT_EN
                if (s_fcnt != 16'(fs_cnt)) fc_err++;
`endif
            end
        end
        check("frame_hcount_errors", e_h, 0);
        check("frame_vcount_errors", e_v, 0);
        check("frame_hblnk_errors", e_hb, 0);
        check("frame_vblnk_errors", e_vb, 0);
        check("frame_hsync_errors", e_hs, 0);
        check("frame_vsync_errors", e_vs, 0);
        check("frame_start_errors", e_fs, 0);
        check("frame_start_count", fs_cnt, 3);
        check("frame_period_errors", per_err, 0);
        check("vsync_cycles_two_frames", vs_cyc, 2 * 2 * 16);
        check("frame_cnt_errors", fc_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
